// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
// Read-side width packer for the dual-clock FIFO. It lives entirely in the
// read clock domain. It pops narrow FIFO words and assembles RATIO of them
// into one wide beat on a valid/ready output stream. A flush request emits
// the partially filled beat, with a lane mask and m_last set.
//
// Ports
//   rclk, rrst_n : read clock; asynchronous active-low reset
//   rdata        : FIFO read data, valid whenever rempty=0
//   rempty       : FIFO empty flag
//   rinc         : FIFO pop (combinational)
//   flush        : single-cycle request to emit the partial beat
//   m_data       : packed beat; lane 0 (bits DSIZE-1:0) holds the oldest word
//   m_keep       : per-lane valid mask
//   m_last       : beat was produced by a flush
//   m_valid      : beat available
//   m_ready      : downstream accepts the beat
//   busy         : partial data, a pending flush, or a held beat exists
//
// Handshake: a beat transfers on any rising edge where m_valid & m_ready.
// While m_valid=1 and m_ready=0, m_data/m_keep/m_last hold steady. A new beat
// may load on the same edge as a transfer, so there is no bubble.
module fifo_rd_packer #(
  parameter int DSIZE = 8,
  parameter int RATIO = 4
) (
  input  logic                   rclk,
  input  logic                   rrst_n,
  input  logic [DSIZE-1:0]       rdata,
  input  logic                   rempty,
  output logic                   rinc,
  input  logic                   flush,
  output logic [RATIO*DSIZE-1:0] m_data,
  output logic [RATIO-1:0]       m_keep,
  output logic                   m_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   busy
);

  localparam int CW = $clog2(RATIO);
  localparam int AW = (RATIO-1)*DSIZE;

  // The accumulator holds only RATIO-1 lanes. The completing word goes
  // straight from rdata into the output register.
  logic [AW-1:0]          acc_q, acc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   flush_pend_q, flush_pend_d;
  logic [RATIO*DSIZE-1:0] m_data_q, m_data_d;
  logic [RATIO-1:0]       m_keep_q, m_keep_d;
  logic                   m_last_q, m_last_d;
  logic                   m_valid_q, m_valid_d;

  logic out_free;
  logic last_lane;

  assign out_free  = !m_valid_q || m_ready;
  assign last_lane = (cnt_q == CW'(RATIO-1));

  // m_ready only matters when the next pop would complete a beat. Earlier
  // lanes land in the accumulator, which is always free.
  assign rinc = rrst_n && !rempty && !flush_pend_q && (!last_lane || out_free);

  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q || flush;
    m_data_d     = m_data_q;
    m_keep_d     = m_keep_q;
    m_last_d     = m_last_q;
    m_valid_d    = m_valid_q && !m_ready;

    if (rinc) begin
      if (!last_lane) begin
        for (int i = 0; i < RATIO-1; i++) begin
          if (cnt_q == CW'(i)) acc_d[i*DSIZE +: DSIZE] = rdata;
        end
        cnt_d = cnt_q + CW'(1);
      end else begin
        m_data_d  = {rdata, acc_q};
        m_keep_d  = '1;
        m_last_d  = 1'b0;
        m_valid_d = 1'b1;
        cnt_d     = '0;
        // Clearing here keeps unfilled lanes at zero for a later partial beat.
        acc_d     = '0;
      end
    end else if (flush_pend_q) begin
      // Pops are blocked while a flush is pending, so this branch never
      // competes with a pop. A flush arriving now is absorbed.
      if (cnt_q == '0) begin
        flush_pend_d = 1'b0;
      end else if (out_free) begin
        m_data_d = {{DSIZE{1'b0}}, acc_q};
        for (int i = 0; i < RATIO; i++) begin
          m_keep_d[i] = (i < int'(cnt_q));
        end
        m_last_d     = 1'b1;
        m_valid_d    = 1'b1;
        cnt_d        = '0;
        acc_d        = '0;
        flush_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      m_data_q     <= '0;
      m_keep_q     <= '0;
      m_last_q     <= 1'b0;
      m_valid_q    <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      m_data_q     <= m_data_d;
      m_keep_q     <= m_keep_d;
      m_last_q     <= m_last_d;
      m_valid_q    <= m_valid_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_keep  = m_keep_q;
  assign m_last  = m_last_q;
  assign m_valid = m_valid_q;
  assign busy    = (cnt_q != '0) || flush_pend_q || m_valid_q;

endmodule
